// File: rtl/freq_gen_pkg.sv
// Shared constants, types and helper functions for the NCO frequency generator.
//   PHASE_STEPS_DEF / DEG_SCALE_DEF : default phase resolution (0.0625 deg)
//   calc_gain()                     : fractional increment per 0.1 Hz per clock
//   deg_to_steps()                  : saturating degrees -> phase steps
package freq_gen_pkg;

  localparam int unsigned PHASE_STEPS_DEF = 5760;
  localparam int unsigned DEG_SCALE_DEF   = 16;

  typedef logic        [15:0] phase_t;
  typedef logic signed [15:0] freq_t;

  // round(2^frac_w * steps / tick_hz); tick_hz is the clock rate times 10
  // because frequencies are carried in 0.1 Hz units.
  function automatic int unsigned calc_gain(input int unsigned     frac_w,
                                            input int unsigned     steps,
                                            input longint unsigned tick_hz);
    longint unsigned num;
    num = (64'd1 << frac_w) * steps;
    return 32'((num + tick_hz / 2) / tick_hz);
  endfunction

  // Shift angles above 359 deg saturate rather than wrap.
  function automatic logic [16:0] deg_to_steps(input logic [8:0]    deg,
                                               input int unsigned   scale);
    logic [8:0] sat;
    sat = (deg > 9'd359) ? 9'd359 : deg;
    return 17'(sat * scale);
  endfunction

endpackage

// File: rtl/freq_generator_nco_ramp.sv
// freq_ramp: target conditioning, free-running ramp divider and slew limiter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_enable       : low clears the applied frequency and the divider
//   i_freq         : requested frequency, 0.1 Hz, signed
//   o_freq_act     : slew-limited frequency actually applied
//   o_at_target    : o_freq_act equals the conditioned target
module freq_ramp
  import freq_gen_pkg::*;
#(
  parameter int FREQ_MAX  = 5000,
  parameter int FREQ_MIN  = 100,
  parameter int RAMP_STEP = 1,
  parameter int RAMP_DIV  = 4000
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_enable,
  input  freq_t i_freq,
  output freq_t o_freq_act,
  output logic  o_at_target
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam freq_t F_MAX = freq_t'(FREQ_MAX);
  localparam freq_t F_MIN = freq_t'(FREQ_MIN);
  localparam logic signed [17:0] STEP_X = 18'(RAMP_STEP);

  freq_t            r_target;
  freq_t            r_freq;
  logic [DIV_W-1:0] r_div;

  freq_t            w_target;
  freq_t            w_freq_next;
  logic signed [17:0] w_tgt_x, w_cur_x, w_diff, w_cand;

  always_comb begin
    w_target = i_freq;
    if (i_freq > FREQ_MAX)                    w_target = F_MAX;
    else if (i_freq < -FREQ_MAX)              w_target = -F_MAX;
    else if (i_freq > 0 && i_freq < FREQ_MIN) w_target = F_MIN;
    else if (i_freq < 0 && i_freq > -FREQ_MIN) w_target = -F_MIN;
  end

  // Step toward the target; a step that would cross zero lands on zero so a
  // reversal always dwells at standstill for one ramp period.
  always_comb begin
    w_tgt_x = {{2{r_target[15]}}, r_target};
    w_cur_x = {{2{r_freq[15]}}, r_freq};
    w_diff  = w_tgt_x - w_cur_x;
    w_cand  = w_cur_x;
    if (w_diff > 0) begin
      w_cand = (w_diff < STEP_X) ? w_tgt_x : w_cur_x + STEP_X;
      if (w_cur_x < 0 && w_cand > 0) w_cand = '0;
    end else if (w_diff < 0) begin
      w_cand = (-w_diff < STEP_X) ? w_tgt_x : w_cur_x - STEP_X;
      if (w_cur_x > 0 && w_cand < 0) w_cand = '0;
    end
    w_freq_next = w_cand[15:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_target <= '0;
      r_freq   <= '0;
      r_div    <= '0;
    end else begin
      r_target <= w_target;
      if (!i_enable) begin
        r_freq <= '0;
        r_div  <= '0;
      end else if (r_div == DIV_LAST) begin
        r_div  <= '0;
        r_freq <= w_freq_next;
      end else begin
        r_div  <= r_div + 1'b1;
      end
    end
  end

  assign o_freq_act  = r_freq;
  assign o_at_target = (r_freq == r_target);

endmodule

// File: rtl/freq_generator_nco.sv
// freq_generator_nco: fractional-accumulator NCO producing a phase index plus
// N_CH shifted copies, a revolution tick and a ramped applied frequency.
//   clk_40_mhz, rst_n : clock, asynchronous active-low reset
//   enable            : low synchronously clears all running state
//   input_freq        : target frequency, 0.1 Hz, sign = direction
//   shift_deg         : per-channel shift in degrees, channel i at [9i+8:9i]
//   phase             : unshifted phase index 0 .. PHASE_STEPS-1
//   phase_shift       : shifted phase indices, channel i at [16i+15:16i]
//   freq_act          : ramped frequency actually applied
//   rev_tick          : one-cycle pulse aligned with a phase wrap
//   at_target         : freq_act equals the conditioned target
module freq_generator_nco
  import freq_gen_pkg::*;
#(
  parameter int          PHASE_STEPS = PHASE_STEPS_DEF,
  parameter int          DEG_SCALE   = DEG_SCALE_DEF,
  parameter int          N_CH        = 3,
  parameter int          FRAC_W      = 32,
  parameter int unsigned GAIN        = calc_gain(FRAC_W, PHASE_STEPS, 64'd400_000_000),
  parameter int          FREQ_MAX    = 5000,
  parameter int          FREQ_MIN    = 100,
  parameter int          RAMP_STEP   = 1,
  parameter int          RAMP_DIV    = 4000
) (
  input  logic                  clk_40_mhz,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic signed [15:0]    input_freq,
  input  logic [N_CH*9-1:0]     shift_deg,
  output logic [15:0]           phase,
  output logic [N_CH*16-1:0]    phase_shift,
  output logic signed [15:0]    freq_act,
  output logic                  rev_tick,
  output logic                  at_target
);

  // At most one carry per clock keeps the phase from skipping indices.
  if (longint'(FREQ_MAX) * longint'(GAIN) >= (64'sd1 <<< FRAC_W)) begin : g_gain_check
    $error("FREQ_MAX * GAIN must be below 2**FRAC_W");
  end
  if (PHASE_STEPS != 360 * DEG_SCALE) begin : g_scale_check
    $error("PHASE_STEPS must equal 360 * DEG_SCALE");
  end

  localparam logic [FRAC_W-1:0] GAIN_W = FRAC_W'(GAIN);
  localparam phase_t            LAST   = phase_t'(PHASE_STEPS - 1);

  logic [FRAC_W-1:0]  r_acc;
  phase_t             r_phase;
  logic [N_CH*16-1:0] r_phase_shift;
  logic               r_rev_tick;

  freq_t              w_freq_act;
  logic [15:0]        w_mag;
  logic [FRAC_W-1:0]  w_inc;
  logic [FRAC_W-1:0]  w_acc_sum;
  logic               w_carry;
  phase_t             w_phase_next;
  logic               w_wrap;
  logic [N_CH*16-1:0] w_phase_shift;

  freq_ramp #(
    .FREQ_MAX  (FREQ_MAX),
    .FREQ_MIN  (FREQ_MIN),
    .RAMP_STEP (RAMP_STEP),
    .RAMP_DIV  (RAMP_DIV)
  ) u_ramp (
    .i_clk       (clk_40_mhz),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_freq      (input_freq),
    .o_freq_act  (w_freq_act),
    .o_at_target (at_target)
  );

  // Zero frequency gives a zero increment, so the accumulator holds.
  always_comb begin
    w_mag = w_freq_act[15] ? 16'(-w_freq_act) : w_freq_act;
    w_inc = FRAC_W'(w_mag) * GAIN_W;
    {w_carry, w_acc_sum} = {1'b0, r_acc} + {1'b0, w_inc};
  end

  always_comb begin
    w_phase_next = r_phase;
    w_wrap       = 1'b0;
    if (w_carry) begin
      if (!w_freq_act[15]) begin
        if (r_phase == LAST) begin
          w_phase_next = '0;
          w_wrap       = 1'b1;
        end else begin
          w_phase_next = r_phase + 16'd1;
        end
      end else begin
        if (r_phase == '0) begin
          w_phase_next = LAST;
          w_wrap       = 1'b1;
        end else begin
          w_phase_next = r_phase - 16'd1;
        end
      end
    end
  end

  // Built from phase_next so the shifted outputs land on the same edge as
  // phase; the sum stays below 2*PHASE_STEPS, one subtract suffices.
  always_comb begin
    logic [16:0] v_sum;
    w_phase_shift = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      v_sum = 17'(w_phase_next) + deg_to_steps(shift_deg[9*i +: 9], DEG_SCALE);
      if (v_sum >= 17'(PHASE_STEPS)) v_sum = v_sum - 17'(PHASE_STEPS);
      w_phase_shift[16*i +: 16] = v_sum[15:0];
    end
  end

  always_ff @(posedge clk_40_mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_phase       <= '0;
      r_phase_shift <= '0;
      r_rev_tick    <= 1'b0;
    end else if (!enable) begin
      r_acc         <= '0;
      r_phase       <= '0;
      r_phase_shift <= '0;
      r_rev_tick    <= 1'b0;
    end else begin
      r_acc         <= w_acc_sum;
      r_phase       <= w_phase_next;
      r_phase_shift <= w_phase_shift;
      r_rev_tick    <= w_wrap;
    end
  end

  assign phase       = r_phase;
  assign phase_shift = r_phase_shift;
  assign freq_act    = w_freq_act;
  assign rev_tick    = r_rev_tick;

endmodule

// File: tb/tb_freq_generator_nco.sv
// Directed bench for freq_generator_nco. FRAC_W=17 / GAIN=64 makes 1024
// (0.1 Hz units) add exactly half the accumulator modulus per clock, so the
// phase steps every second clock and a revolution is exactly 11520 clocks.
module tb_freq_generator_nco;

  localparam int N_CH = 3;

  logic                     clk_40_mhz = 1'b0;
  logic                     rst_n      = 1'b0;
  logic                     enable     = 1'b0;
  logic signed [15:0]       input_freq = '0;
  logic [N_CH*9-1:0]        shift_deg  = '0;
  logic [15:0]              phase;
  logic [N_CH*16-1:0]       phase_shift;
  logic signed [15:0]       freq_act;
  logic                     rev_tick;
  logic                     at_target;

  int vectors = 0;
  int errors  = 0;

  freq_generator_nco #(
    .N_CH      (N_CH),
    .FRAC_W    (17),
    .GAIN      (64),
    .FREQ_MAX  (2000),
    .FREQ_MIN  (100),
    .RAMP_STEP (1),
    .RAMP_DIV  (4)
  ) dut (
    .clk_40_mhz  (clk_40_mhz),
    .rst_n       (rst_n),
    .enable      (enable),
    .input_freq  (input_freq),
    .shift_deg   (shift_deg),
    .phase       (phase),
    .phase_shift (phase_shift),
    .freq_act    (freq_act),
    .rev_tick    (rev_tick),
    .at_target   (at_target)
  );

  always #5 clk_40_mhz = ~clk_40_mhz;

  task automatic tick(input int n);
    repeat (n) @(negedge clk_40_mhz);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; input_freq = 16'sd500;
    shift_deg = {9'd10, 9'd20, 9'd30};
    tick(3);
    vectors++; if (phase !== 16'd0) begin errors++; $display("FAIL rst_phase: got %0d want 0", phase); end
    vectors++; if (phase_shift !== 48'd0) begin errors++; $display("FAIL rst_shift: got %h want 0", phase_shift); end
    vectors++; if (freq_act !== 16'sd0) begin errors++; $display("FAIL rst_freq: got %0d want 0", freq_act); end
    vectors++; if (rev_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b want 0", rev_tick); end
    vectors++; if (at_target !== 1'b1) begin errors++; $display("FAIL rst_at_target: got %b want 1", at_target); end
    rst_n = 1'b1;
    tick(5);
    vectors++; if (phase !== 16'd0) begin errors++; $display("FAIL dis_phase: got %0d want 0", phase); end
    vectors++; if (phase_shift !== 48'd0) begin errors++; $display("FAIL dis_shift: got %h want 0", phase_shift); end
    vectors++; if (freq_act !== 16'sd0) begin errors++; $display("FAIL dis_freq: got %0d want 0", freq_act); end
    vectors++; if (rev_tick !== 1'b0) begin errors++; $display("FAIL dis_tick: got %b want 0", rev_tick); end
  endtask

  task automatic test_shift_stationary();
    input_freq = 16'sd0; shift_deg = '0; enable = 1'b1;
    tick(3);
    shift_deg = {9'd0, 9'd90, 9'd0};
    tick(1);
    vectors++; if (phase_shift !== {16'd0, 16'd1440, 16'd0}) begin errors++; $display("FAIL stat_shift: got %h want 0000_05a0_0000", phase_shift); end
    vectors++; if (phase !== 16'd0) begin errors++; $display("FAIL stat_phase: got %0d want 0", phase); end
    vectors++; if (at_target !== 1'b1) begin errors++; $display("FAIL stat_at_target: got %b want 1", at_target); end
  endtask

  task automatic test_ramp();
    int n;
    shift_deg = '0; input_freq = 16'sd500;
    tick(100);
    n = 100;
    vectors++; if (at_target !== 1'b0) begin errors++; $display("FAIL ramp_mid_at_target: got %b want 0", at_target); end
    vectors++; if (!(freq_act > 0 && freq_act < 500)) begin errors++; $display("FAIL ramp_mid_freq: got %0d want 1..499", freq_act); end
    while (freq_act !== 16'sd500 && n < 3000) begin tick(1); n++; end
    vectors++; if (!(n >= 1996 && n <= 2004)) begin errors++; $display("FAIL ramp_time: got %0d cycles want 1996..2004", n); end
    vectors++; if (at_target !== 1'b1) begin errors++; $display("FAIL ramp_at_target: got %b want 1", at_target); end
    tick(40);
    vectors++; if (freq_act !== 16'sd500) begin errors++; $display("FAIL ramp_hold: got %0d want 500", freq_act); end
  endtask

  task automatic test_accuracy_shift();
    int n;
    input_freq = 16'sd1024;
    n = 0;
    while (freq_act !== 16'sd1024 && n < 3000) begin tick(1); n++; end
    vectors++; if (freq_act !== 16'sd1024) begin errors++; $display("FAIL acc_ramp: got %0d want 1024", freq_act); end
    n = 0;
    while (rev_tick !== 1'b1 && n < 12000) begin tick(1); n++; end
    vectors++; if (rev_tick !== 1'b1) begin errors++; $display("FAIL acc_first_tick: got %b want 1 within 12000 cycles", rev_tick); end
    vectors++; if (phase !== 16'd0) begin errors++; $display("FAIL acc_wrap_phase: got %0d want 0", phase); end
    shift_deg = {9'd240, 9'd120, 9'd0};
    tick(10000);
    vectors++; if (phase !== 16'd5000) begin errors++; $display("FAIL shift_phase: got %0d want 5000", phase); end
    vectors++; if (phase_shift !== {16'd3080, 16'd1160, 16'd5000}) begin errors++; $display("FAIL shift_0_120_240: got %h want 0c08_0488_1388", phase_shift); end
    shift_deg = {9'd1, 9'd359, 9'd400};
    n = 10000;
    while (rev_tick !== 1'b1 && n < 13000) begin tick(1); n++; end
    vectors++; if (n !== 11520) begin errors++; $display("FAIL rev_interval_1: got %0d want 11520", n); end
    tick(10000);
    vectors++; if (phase !== 16'd5000) begin errors++; $display("FAIL sat_phase: got %0d want 5000", phase); end
    vectors++; if (phase_shift !== {16'd5016, 16'd4984, 16'd4984}) begin errors++; $display("FAIL shift_sat_400: got %h want 1398_1378_1378", phase_shift); end
    n = 10000;
    while (rev_tick !== 1'b1 && n < 13000) begin tick(1); n++; end
    vectors++; if (n !== 11520) begin errors++; $display("FAIL rev_interval_2: got %0d want 11520", n); end
  endtask

  task automatic test_reversal();
    int n, zeros, bad_step, d;
    logic signed [15:0] prev;
    shift_deg = '0; input_freq = -16'sd1024;
    n = 0; zeros = 0; bad_step = 0; prev = freq_act;
    while (freq_act !== -16'sd1024 && n < 10000) begin
      tick(1); n++;
      if (freq_act === 16'sd0) zeros++;
      d = int'(freq_act) - int'(prev);
      if (d > 0 || d < -1) bad_step++;
      prev = freq_act;
    end
    vectors++; if (freq_act !== -16'sd1024) begin errors++; $display("FAIL rev_reach: got %0d want -1024", freq_act); end
    vectors++; if (zeros !== 4) begin errors++; $display("FAIL rev_zero_dwell: got %0d cycles want 4", zeros); end
    vectors++; if (bad_step !== 0) begin errors++; $display("FAIL rev_linear: got %0d bad steps want 0", bad_step); end
    n = 0;
    while (rev_tick !== 1'b1 && n < 12000) begin tick(1); n++; end
    vectors++; if (rev_tick !== 1'b1) begin errors++; $display("FAIL rev_tick_neg: got %b want 1 within 12000 cycles", rev_tick); end
    vectors++; if (phase !== 16'd5759) begin errors++; $display("FAIL rev_wrap_phase: got %0d want 5759", phase); end
    tick(2);
    vectors++; if (phase !== 16'd5758) begin errors++; $display("FAIL rev_decrement: got %0d want 5758", phase); end
  endtask

  task automatic test_min();
    int n;
    input_freq = -16'sd30;
    n = 0;
    while (freq_act !== -16'sd100 && n < 5000) begin tick(1); n++; end
    tick(20);
    vectors++; if (freq_act !== -16'sd100) begin errors++; $display("FAIL min_freq: got %0d want -100", freq_act); end
    vectors++; if (at_target !== 1'b1) begin errors++; $display("FAIL min_at_target: got %b want 1", at_target); end
  endtask

  task automatic test_clamp();
    int n;
    input_freq = 16'sd7000;
    n = 0;
    while (freq_act !== 16'sd2000 && n < 9000) begin tick(1); n++; end
    tick(20);
    vectors++; if (freq_act !== 16'sd2000) begin errors++; $display("FAIL clamp_freq: got %0d want 2000", freq_act); end
    vectors++; if (at_target !== 1'b1) begin errors++; $display("FAIL clamp_at_target: got %b want 1", at_target); end
  endtask

  task automatic test_enable_drop();
    shift_deg = {9'd90, 9'd90, 9'd90}; input_freq = -16'sd2000;
    tick(100);
    vectors++; if (at_target !== 1'b0) begin errors++; $display("FAIL drop_mid_ramp: got %b want 0", at_target); end
    enable = 1'b0;
    tick(1);
    vectors++; if (freq_act !== 16'sd0) begin errors++; $display("FAIL drop_freq: got %0d want 0", freq_act); end
    vectors++; if (phase !== 16'd0) begin errors++; $display("FAIL drop_phase: got %0d want 0", phase); end
    vectors++; if (phase_shift !== 48'd0) begin errors++; $display("FAIL drop_shift: got %h want 0", phase_shift); end
    vectors++; if (rev_tick !== 1'b0) begin errors++; $display("FAIL drop_tick: got %b want 0", rev_tick); end
    enable = 1'b1;
    tick(1);
    vectors++; if (freq_act !== 16'sd0) begin errors++; $display("FAIL reen_freq: got %0d want 0", freq_act); end
    vectors++; if (phase_shift !== {16'd1440, 16'd1440, 16'd1440}) begin errors++; $display("FAIL reen_shift: got %h want 05a0_05a0_05a0", phase_shift); end
  endtask

  task automatic test_async_reset();
    tick(200);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (freq_act !== 16'sd0) begin errors++; $display("FAIL arst_freq: got %0d want 0", freq_act); end
    vectors++; if (phase !== 16'd0) begin errors++; $display("FAIL arst_phase: got %0d want 0", phase); end
    vectors++; if (phase_shift !== 48'd0) begin errors++; $display("FAIL arst_shift: got %h want 0", phase_shift); end
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_shift_stationary();
    test_ramp();
    test_accuracy_shift();
    test_reversal();
    test_min();
    test_clamp();
    test_enable_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
